// File: rtl/s3_pipe_pkg.sv
// Shared types for the execute->writeback skid stage.
// Holds default widths, the FSM state encoding and the entry record.
package s3_pipe_pkg;

    localparam int S3_DATA_W = 32;
    localparam int S3_ADDR_W = 5;

    // Encoding doubles as the occupancy count.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_e;

    typedef struct packed {
        logic                 valid;
        logic                 wen;
        logic [S3_ADDR_W-1:0] wsel;
        logic [S3_DATA_W-1:0] data;
    } entry_t;

endpackage

// File: rtl/s3_wb_skid_stage_if.sv
// Handshake, forwarding and status bundle of the writeback skid stage.
// master: upstream/downstream environment; slave: the stage itself.
interface s3_wb_skid_stage_if
    import s3_pipe_pkg::*;
#(
    parameter int DATA_W = S3_DATA_W,
    parameter int ADDR_W = S3_ADDR_W
) ();

    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [ADDR_W-1:0] in_wsel;
    logic              in_wen;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [ADDR_W-1:0] out_wsel;
    logic              out_wen;
    logic [ADDR_W-1:0] fwd_rsel;
    logic              fwd_hit;
    logic [DATA_W-1:0] fwd_data;
    logic [1:0]        occupancy;

    modport master (
        output flush, in_valid, in_data, in_wsel, in_wen,
        output out_ready, fwd_rsel,
        input  in_ready, out_valid, out_data, out_wsel, out_wen,
        input  fwd_hit, fwd_data, occupancy
    );

    modport slave (
        input  flush, in_valid, in_data, in_wsel, in_wen,
        input  out_ready, fwd_rsel,
        output in_ready, out_valid, out_data, out_wsel, out_wen,
        output fwd_hit, fwd_data, occupancy
    );

endinterface

// File: rtl/s3_pipe_entry.sv
// One load-enabled pipeline entry register (wen, wsel, data).
// Ports: clk, rst (async, active-high), load_i, *_i next values, *_o held values.
module s3_pipe_entry
    import s3_pipe_pkg::*;
#(
    parameter int DATA_W = S3_DATA_W,
    parameter int ADDR_W = S3_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic              wen_i,
    input  logic [ADDR_W-1:0] wsel_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              wen_o,
    output logic [ADDR_W-1:0] wsel_o,
    output logic [DATA_W-1:0] data_o
);

    logic              wen_q;
    logic [ADDR_W-1:0] wsel_q;
    logic [DATA_W-1:0] data_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wen_q  <= 1'b0;
            wsel_q <= '0;
            data_q <= '0;
        end else if (load_i) begin
            wen_q  <= wen_i;
            wsel_q <= wsel_i;
            data_q <= data_i;
        end
    end

    assign wen_o  = wen_q;
    assign wsel_o = wsel_q;
    assign data_o = data_q;

endmodule

// File: rtl/s3_wb_skid_stage.sv
// Execute->writeback stage: valid/ready handshake, 2-entry skid, flush, bypass lookup.
// Ports: clk, rst (async, active-high), bus (slave side of s3_wb_skid_stage_if).
module s3_wb_skid_stage
    import s3_pipe_pkg::*;
#(
    parameter int DATA_W      = S3_DATA_W,
    parameter int ADDR_W      = S3_ADDR_W,
    parameter int SKID        = 1,
    parameter int SUPPRESS_R0 = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    s3_wb_skid_stage_if.slave    bus
);

    state_e state_q, state_d;
    logic   rdy_q, rdy_d;

    logic main_v, skid_v;
    logic in_ready, in_fire, out_fire;
    logic cap_wen;

    logic main_ld, skid_ld, main_from_skid;

    logic              main_wen_d;
    logic [ADDR_W-1:0] main_wsel_d;
    logic [DATA_W-1:0] main_data_d;

    logic              main_wen, skid_wen;
    logic [ADDR_W-1:0] main_wsel, skid_wsel;
    logic [DATA_W-1:0] main_data, skid_data;

    logic main_hit, skid_hit;

    // Valid bits live in the state encoding, not in the entries.
    assign main_v = (state_q != EMPTY);
    assign skid_v = (state_q == TWO);

    // rdy_q also holds ready low for one edge after reset in both modes.
    assign in_ready = (SKID != 0) ? rdy_q
                                  : rdy_q & (~main_v | bus.out_ready);

    assign in_fire  = bus.in_valid & in_ready;
    assign out_fire = main_v & bus.out_ready;

    // Writes to r0 are turned into no-ops at capture time.
    assign cap_wen = bus.in_wen
                   & ((SUPPRESS_R0 == 0) | (|bus.in_wsel));

    always_comb begin
        state_d        = state_q;
        main_ld        = 1'b0;
        skid_ld        = 1'b0;
        main_from_skid = 1'b0;
        if (bus.flush) begin
            state_d = EMPTY;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        state_d = ONE;
                        main_ld = 1'b1;
                    end
                end
                ONE: begin
                    if (in_fire && bus.out_ready) begin
                        main_ld = 1'b1;
                    end else if (in_fire && (SKID != 0)) begin
                        state_d = TWO;
                        skid_ld = 1'b1;
                    end else if (out_fire) begin
                        state_d = EMPTY;
                    end
                end
                TWO: begin
                    if (out_fire) begin
                        state_d        = ONE;
                        main_ld        = 1'b1;
                        main_from_skid = 1'b1;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    assign rdy_d = (state_d != TWO);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rdy_q   <= rdy_d;
        end
    end

    assign main_wen_d  = main_from_skid ? skid_wen  : cap_wen;
    assign main_wsel_d = main_from_skid ? skid_wsel : bus.in_wsel;
    assign main_data_d = main_from_skid ? skid_data : bus.in_data;

    s3_pipe_entry #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_main (
        .clk    (clk),
        .rst    (rst),
        .load_i (main_ld),
        .wen_i  (main_wen_d),
        .wsel_i (main_wsel_d),
        .data_i (main_data_d),
        .wen_o  (main_wen),
        .wsel_o (main_wsel),
        .data_o (main_data)
    );

    s3_pipe_entry #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_skid (
        .clk    (clk),
        .rst    (rst),
        .load_i (skid_ld),
        .wen_i  (cap_wen),
        .wsel_i (bus.in_wsel),
        .data_i (bus.in_data),
        .wen_o  (skid_wen),
        .wsel_o (skid_wsel),
        .data_o (skid_data)
    );

    assign main_hit = main_v & main_wen
                    & (main_wsel == bus.fwd_rsel);
    assign skid_hit = (SKID != 0) & skid_v & skid_wen
                    & (skid_wsel == bus.fwd_rsel);

    // Skid entry is younger, so it wins the bypass.
    assign bus.fwd_hit  = main_hit | skid_hit;
    assign bus.fwd_data = skid_hit ? skid_data
                        : main_hit ? main_data
                        : '0;

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = main_v;
    assign bus.out_data  = main_data;
    assign bus.out_wsel  = main_wsel;
    assign bus.out_wen   = main_v & main_wen;
    assign bus.occupancy = state_q;

endmodule

// File: tb/tb_s3_wb_skid_stage.sv
// Directed self-checking bench for s3_wb_skid_stage (SKID=1, SUPPRESS_R0=1).
// Each scenario task drives stimulus and compares outputs against hand-derived values.
module tb_s3_wb_skid_stage;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    s3_wb_skid_stage_if #(.DATA_W(32), .ADDR_W(5)) bus ();

    s3_wb_skid_stage #(
        .DATA_W      (32),
        .ADDR_W      (5),
        .SKID        (1),
        .SUPPRESS_R0 (1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] d,
                         input logic [4:0] w, input logic e);
        bus.in_valid = v;
        bus.in_data  = d;
        bus.in_wsel  = w;
        bus.in_wen   = e;
    endtask

    task automatic test_reset();
        rst           = 1'b1;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        bus.fwd_rsel  = 5'd0;
        drive(1'b0, 32'h0, 5'd0, 1'b0);
        #2;
        checks++;
        if ({bus.out_valid, bus.out_wen, bus.fwd_hit, bus.occupancy, bus.in_ready}
            !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctl got v=%b wen=%b hit=%b occ=%0d rdy=%b want all 0",
                     bus.out_valid, bus.out_wen, bus.fwd_hit, bus.occupancy, bus.in_ready);
        end
        checks++;
        if ({bus.out_data, bus.out_wsel} !== 37'h0) begin
            errors++;
            $display("FAIL reset_data got data=%h wsel=%0d want 0/0",
                     bus.out_data, bus.out_wsel);
        end
        step();
        rst = 1'b0;
        #1;
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_rdy_before_edge got %b want 0", bus.in_ready);
        end
        step();
        checks++;
        if ({bus.in_ready, bus.occupancy} !== 3'b100) begin
            errors++;
            $display("FAIL reset_rdy_after_edge got rdy=%b occ=%0d want 1/0",
                     bus.in_ready, bus.occupancy);
        end
    endtask

    task automatic test_stream();
        logic [31:0] d [3];
        logic [4:0]  w [3];
        d[0] = 32'hA; d[1] = 32'hB; d[2] = 32'hC;
        w[0] = 5'd3;  w[1] = 5'd4;  w[2] = 5'd5;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, d[i], w[i], 1'b1);
            step();
            checks++;
            if ({bus.out_valid, bus.out_data, bus.out_wsel, bus.out_wen, bus.in_ready}
                !== {1'b1, d[i], w[i], 1'b1, 1'b1}) begin
                errors++;
                $display("FAIL stream_%0d got v=%b d=%h w=%0d wen=%b rdy=%b want 1/%h/%0d/1/1",
                         i, bus.out_valid, bus.out_data, bus.out_wsel, bus.out_wen,
                         bus.in_ready, d[i], w[i]);
            end
        end
        drive(1'b0, 32'h0, 5'd0, 1'b0);
        step();
        checks++;
        if ({bus.out_valid, bus.out_wen, bus.occupancy} !== 4'b0) begin
            errors++;
            $display("FAIL stream_drain got v=%b wen=%b occ=%0d want 0/0/0",
                     bus.out_valid, bus.out_wen, bus.occupancy);
        end
    endtask

    task automatic test_backpressure();
        bus.out_ready = 1'b0;
        drive(1'b1, 32'h11, 5'd1, 1'b1);
        step();
        checks++;
        if ({bus.occupancy, bus.in_ready} !== 3'b011) begin
            errors++;
            $display("FAIL bp_one got occ=%0d rdy=%b want 1/1",
                     bus.occupancy, bus.in_ready);
        end
        drive(1'b1, 32'h22, 5'd2, 1'b1);
        step();
        drive(1'b0, 32'h0, 5'd0, 1'b0);
        checks++;
        if ({bus.occupancy, bus.in_ready, bus.out_data} !== {2'd2, 1'b0, 32'h11}) begin
            errors++;
            $display("FAIL bp_full got occ=%0d rdy=%b d=%h want 2/0/11",
                     bus.occupancy, bus.in_ready, bus.out_data);
        end
        step();
        checks++;
        if ({bus.occupancy, bus.out_data} !== {2'd2, 32'h11}) begin
            errors++;
            $display("FAIL bp_hold got occ=%0d d=%h want 2/11",
                     bus.occupancy, bus.out_data);
        end
        bus.out_ready = 1'b1;
        step();
        checks++;
        if ({bus.out_valid, bus.out_data, bus.out_wsel, bus.in_ready, bus.occupancy}
            !== {1'b1, 32'h22, 5'd2, 1'b1, 2'd1}) begin
            errors++;
            $display("FAIL bp_second got v=%b d=%h w=%0d rdy=%b occ=%0d want 1/22/2/1/1",
                     bus.out_valid, bus.out_data, bus.out_wsel, bus.in_ready,
                     bus.occupancy);
        end
        step();
        checks++;
        if ({bus.out_valid, bus.occupancy, bus.in_ready} !== 4'b0001) begin
            errors++;
            $display("FAIL bp_empty got v=%b occ=%0d rdy=%b want 0/0/1",
                     bus.out_valid, bus.occupancy, bus.in_ready);
        end
    endtask

    task automatic test_forwarding();
        bus.out_ready = 1'b0;
        drive(1'b1, 32'h11, 5'd7, 1'b1);
        step();
        drive(1'b1, 32'h22, 5'd7, 1'b1);
        step();
        drive(1'b0, 32'h0, 5'd0, 1'b0);
        bus.fwd_rsel = 5'd7;
        #1;
        checks++;
        if ({bus.fwd_hit, bus.fwd_data} !== {1'b1, 32'h22}) begin
            errors++;
            $display("FAIL fwd_skid got hit=%b d=%h want 1/22",
                     bus.fwd_hit, bus.fwd_data);
        end
        bus.fwd_rsel = 5'd6;
        #1;
        checks++;
        if ({bus.fwd_hit, bus.fwd_data} !== {1'b0, 32'h0}) begin
            errors++;
            $display("FAIL fwd_miss got hit=%b d=%h want 0/0",
                     bus.fwd_hit, bus.fwd_data);
        end
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        bus.fwd_rsel  = 5'd7;
        #1;
        checks++;
        if ({bus.fwd_hit, bus.fwd_data, bus.occupancy} !== {1'b1, 32'h22, 2'd1}) begin
            errors++;
            $display("FAIL fwd_main got hit=%b d=%h occ=%0d want 1/22/1",
                     bus.fwd_hit, bus.fwd_data, bus.occupancy);
        end
        bus.out_ready = 1'b1;
        step();
        checks++;
        if ({bus.fwd_hit, bus.fwd_data} !== {1'b0, 32'h0}) begin
            errors++;
            $display("FAIL fwd_empty got hit=%b d=%h want 0/0",
                     bus.fwd_hit, bus.fwd_data);
        end
    endtask

    task automatic test_r0();
        bus.out_ready = 1'b0;
        drive(1'b1, 32'h55, 5'd0, 1'b1);
        step();
        drive(1'b0, 32'h0, 5'd0, 1'b0);
        bus.fwd_rsel = 5'd0;
        #1;
        checks++;
        if ({bus.out_valid, bus.out_wen, bus.out_data} !== {1'b1, 1'b0, 32'h55}) begin
            errors++;
            $display("FAIL r0_wen got v=%b wen=%b d=%h want 1/0/55",
                     bus.out_valid, bus.out_wen, bus.out_data);
        end
        checks++;
        if (bus.fwd_hit !== 1'b0) begin
            errors++;
            $display("FAIL r0_fwd got hit=%b want 0", bus.fwd_hit);
        end
        bus.out_ready = 1'b1;
        step();
    endtask

    task automatic test_flush();
        bus.out_ready = 1'b0;
        drive(1'b1, 32'h31, 5'd1, 1'b1);
        step();
        drive(1'b1, 32'h32, 5'd2, 1'b1);
        step();
        drive(1'b1, 32'h99, 5'd9, 1'b1);
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        drive(1'b0, 32'h0, 5'd0, 1'b0);
        checks++;
        if ({bus.occupancy, bus.out_valid, bus.out_wen, bus.in_ready} !== 5'b00001) begin
            errors++;
            $display("FAIL flush_two got occ=%0d v=%b wen=%b rdy=%b want 0/0/0/1",
                     bus.occupancy, bus.out_valid, bus.out_wen, bus.in_ready);
        end
        bus.out_ready = 1'b1;
        drive(1'b1, 32'h44, 5'd4, 1'b1);
        step();
        drive(1'b0, 32'h0, 5'd0, 1'b0);
        checks++;
        if ({bus.out_valid, bus.out_data, bus.out_wsel} !== {1'b1, 32'h44, 5'd4}) begin
            errors++;
            $display("FAIL flush_next got v=%b d=%h w=%0d want 1/44/4",
                     bus.out_valid, bus.out_data, bus.out_wsel);
        end
        bus.out_ready = 1'b0;
        drive(1'b1, 32'h77, 5'd7, 1'b1);
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        drive(1'b0, 32'h0, 5'd0, 1'b0);
        checks++;
        if ({bus.occupancy, bus.out_valid, bus.in_ready} !== 4'b0001) begin
            errors++;
            $display("FAIL flush_one got occ=%0d v=%b rdy=%b want 0/0/1",
                     bus.occupancy, bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic test_reset_midstream();
        bus.out_ready = 1'b0;
        drive(1'b1, 32'h61, 5'd1, 1'b1);
        step();
        drive(1'b1, 32'h62, 5'd2, 1'b1);
        step();
        drive(1'b0, 32'h0, 5'd0, 1'b0);
        checks++;
        if (bus.occupancy !== 2'd2) begin
            errors++;
            $display("FAIL mid_fill got occ=%0d want 2", bus.occupancy);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.out_valid, bus.occupancy, bus.in_ready, bus.out_data}
            !== {1'b0, 2'd0, 1'b0, 32'h0}) begin
            errors++;
            $display("FAIL mid_reset got v=%b occ=%0d rdy=%b d=%h want 0/0/0/0",
                     bus.out_valid, bus.occupancy, bus.in_ready, bus.out_data);
        end
        step();
        rst = 1'b0;
        #1;
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_rdy_low got %b want 0", bus.in_ready);
        end
        step();
        checks++;
        if ({bus.in_ready, bus.occupancy} !== 3'b100) begin
            errors++;
            $display("FAIL mid_rdy_high got rdy=%b occ=%0d want 1/0",
                     bus.in_ready, bus.occupancy);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_stream();
        test_backpressure();
        test_forwarding();
        test_r0();
        test_flush();
        test_reset_midstream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
